// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: one sum bit per cycle, LSB first, with the parallel result collected in a shift register.
// Latency: WIDTH RUN cycles after the start is accepted, then a one-cycle DONE; back-to-back period is WIDTH+2.
// Backpressure: none; start is honoured only in IDLE and dropped otherwise, with no queueing.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   start, a, b     begin request and operands, captured together when accepted in IDLE
//   busy            high while an addition is running
//   sum_bit         serial sum bit (LSB first), meaningful only while sum_valid is high
//   sum, carry_out  parallel result and final carry, held from DONE until the next accepted start
//   done            one-cycle completion pulse
//   overflow        signed overflow of the MSB stage; present only when SERIAL_ADDER_OVF_EN is defined
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             sum_bit,
    output logic             sum_valid,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             done
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             overflow
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_r;
    logic [CW-1:0]    cnt;
    logic             c;
    logic             c_nxt;
    logic             bit_now;
    logic             last;
    logic             load;
    logic             cout_r;

    // Full-adder stage on the current LSBs.
    assign bit_now = a_sh[0] ^ b_sh[0] ^ c;
    assign c_nxt   = (a_sh[0] & b_sh[0]) | (a_sh[0] & c) | (b_sh[0] & c);
    assign last    = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Outputs are decoded from state so that reset clears them immediately.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        busy      = 1'b0;
        sum_valid = 1'b0;
        sum_bit   = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy      = 1'b1;
                sum_valid = 1'b1;
                sum_bit   = bit_now;
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_r  <= '0;
            cnt    <= '0;
            c      <= 1'b0;
            cout_r <= 1'b0;
        end else if (load) begin
            a_sh   <= a;
            b_sh   <= b;
            sum_r  <= '0;
            cnt    <= '0;
            c      <= 1'b0;
            cout_r <= 1'b0;
        end else if (state == RUN) begin
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            // Result enters at the MSB so the first (LSB) bit ends up at bit 0 after WIDTH shifts.
            sum_r <= {bit_now, sum_r[WIDTH-1:1]};
            cnt   <= cnt + CW'(1);
            c     <= c_nxt;
            if (last) begin
                cout_r <= c_nxt;
            end
        end
    end

    assign sum       = sum_r;
    assign carry_out = cout_r;

`ifdef SERIAL_ADDER_OVF_EN
    logic ovf_r;

    // Signed overflow: carry into the MSB stage differs from carry out of it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_r <= 1'b0;
        end else if (load) begin
            ovf_r <= 1'b0;
        end else if (state == RUN && last) begin
            ovf_r <= c ^ c_nxt;
        end
    end

    assign overflow = ovf_r;
`endif

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         sum_bit;
    logic         sum_valid;
    logic [W-1:0] sum;
    logic         carry_out;
    logic         done;
`ifdef SERIAL_ADDER_OVF_EN
    logic         overflow;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .sum_bit   (sum_bit),
        .sum_valid (sum_valid),
        .sum       (sum),
        .carry_out (carry_out),
        .done      (done)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .overflow  (overflow)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference: plain integer addition; bit i of the true sum is the i-th serial bit.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input bit noisy, input string tag);
        int unsigned full;
        logic [W-1:0] exp_sum;
        logic         exp_c;
        logic         exp_ovf;
        full    = int'(ta) + int'(tb_);
        exp_sum = full[W-1:0];
        exp_c   = full[W];
        exp_ovf = (ta[W-1] == tb_[W-1]) && (exp_sum[W-1] != ta[W-1]);

        @(negedge clk);
        a = ta; b = tb_; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (noisy) begin a = W'($urandom); b = W'($urandom); end
        for (int i = 0; i < W; i++) begin
            check({tag, "_run"}, {busy, sum_valid, done, sum_bit}, {1'b1, 1'b1, 1'b0, full[i]});
            if (noisy) begin
                start = 1'($urandom_range(0, 1));
                a = W'($urandom);
                b = W'($urandom);
            end
            @(negedge clk);
        end
        start = 1'b0;
        check({tag, "_done"}, {done, busy, sum_valid}, 3'b100);
        check({tag, "_sum"}, sum, exp_sum);
        check({tag, "_cout"}, carry_out, exp_c);
`ifdef SERIAL_ADDER_OVF_EN
        check({tag, "_ovf"}, overflow, exp_ovf);
`endif
        repeat (3) begin
            @(negedge clk);
            check({tag, "_idle"}, {done, busy}, 2'b00);
            check({tag, "_hold"}, {carry_out, sum}, {exp_c, exp_sum});
        end
    endtask

    int done_cyc[$];

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        check("reset_outs", {busy, sum_valid, sum_bit, done, carry_out, sum},
              {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, W'(0)});
        rst = 1'b0;

        run_op(8'h0F, 8'h01, 1'b0, "ex_0f_01");
        run_op(8'hFF, 8'h01, 1'b0, "ex_ff_01");
        run_op(8'h7F, 8'h01, 1'b0, "ex_7f_01");
        run_op(8'h80, 8'h80, 1'b0, "ex_80_80");
        run_op(8'hFF, 8'hFF, 1'b0, "ex_ff_ff");

        // Restart mid-run must be ignored and operand changes must not leak in.
        @(negedge clk);
        a = 8'h03; b = 8'h04; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        a = 8'hAA; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        done_cyc.delete();
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (done) begin
                done_cyc.push_back(cyc);
                check("ignore_sum", sum, 8'h07);
            end
            @(negedge clk);
        end
        check("ignore_one_done", done_cyc.size(), 1);
        check("ignore_sum_hold", sum, 8'h07);

        run_op(8'h00, 8'h00, 1'b1, "noisy_00_00");
        for (int k = 0; k < 20; k++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), "rand");
        end

        // Reset three cycles into RUN.
        @(negedge clk);
        a = 8'hFF; b = 8'hFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_busy", busy, 1'b1);
        rst = 1'b1;
        #1;
        check("rst_outs", {busy, sum_valid, sum_bit, done, carry_out, sum},
              {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, W'(0)});
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            if (cyc == 2) rst = 1'b0;
            check("rst_no_done", done, 1'b0);
        end
        run_op(8'h01, 8'h01, 1'b0, "post_rst");

        // start held for 25 cycles: accepts at cycles 0,10,20 -> done at 9,19,29.
        @(negedge clk);
        a = 8'h12; b = 8'h34; start = 1'b1;
        done_cyc.delete();
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (cyc == 25) start = 1'b0;
            @(negedge clk);
            if (done) begin
                done_cyc.push_back(cyc + 1);
                check("b2b_sum", sum, 8'h46);
            end
        end
        check("b2b_count", done_cyc.size(), 3);
        if (done_cyc.size() >= 1) check("b2b_first_latency", done_cyc[0], W + 1);
        for (int i = 1; i < done_cyc.size(); i++) begin
            check("b2b_period", done_cyc[i] - done_cyc[i-1], W + 2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
